// File: rtl/obj_dma_scheduler_if.sv
// obj_dma_scheduler_if: timing, CPU, source-RAM and shadow-RAM signals of the object DMA scheduler
interface obj_dma_scheduler_if #(
  parameter int AW = 10,
  parameter int DW = 16
);
  logic          i_EMU_CLK6MPCEN_n;
  logic [8:0]    i_HCOUNTER;
  logic [8:0]    i_VCOUNTER;
  logic          i_DMA_EN;
  logic          i_CPU_CS_n;
  logic          i_CPU_WR_n;
  logic [AW-1:0] i_CPU_ADDR;
  logic          o_CPU_WAIT_n;
  logic [AW-1:0] o_SRC_ADDR;
  logic          o_SRC_WE;
  logic [DW-1:0] i_SRC_DATA;
  logic [AW-1:0] o_DST_ADDR;
  logic [DW-1:0] o_DST_DATA;
  logic          o_DST_WE;
  logic          o_BUSY;
  logic          o_DONE;
  logic          o_DMA_ERR;
  modport slave (
    input  i_EMU_CLK6MPCEN_n, i_HCOUNTER, i_VCOUNTER, i_DMA_EN, i_CPU_CS_n, i_CPU_WR_n, i_CPU_ADDR, i_SRC_DATA,
    output o_CPU_WAIT_n, o_SRC_ADDR, o_SRC_WE, o_DST_ADDR, o_DST_DATA, o_DST_WE, o_BUSY, o_DONE, o_DMA_ERR
  );
  modport master (
    output i_EMU_CLK6MPCEN_n, i_HCOUNTER, i_VCOUNTER, i_DMA_EN, i_CPU_CS_n, i_CPU_WR_n, i_CPU_ADDR, i_SRC_DATA,
    input  o_CPU_WAIT_n, o_SRC_ADDR, o_SRC_WE, o_DST_ADDR, o_DST_DATA, o_DST_WE, o_BUSY, o_DONE, o_DMA_ERR
  );
endinterface

// File: rtl/obj_dma_scheduler.sv
// obj_dma_scheduler: per-frame object RAM copy into the shadow RAM during the vertical DMA window
module obj_dma_scheduler #(
  parameter int AW             = 10,
  parameter int DW             = 16,
  parameter int WORDS          = 1024,
  parameter int DMA_FIRST_LINE = 479,
  parameter int DMA_LAST_LINE  = 494,
  parameter int TRIG_HCOUNT    = 128
) (
  input logic                i_EMU_MCLK,
  input logic                i_MRST_n,
  obj_dma_scheduler_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ARMED, COPY, DONE} state_t;
  localparam logic [AW:0] LP_WORDS = (AW+1)'(WORDS);
  state_t        r_state;
  logic [AW:0]   r_rd_ptr;
  logic          r_fin;
  logic [AW-1:0] r_src_addr;
  logic [AW-1:0] r_dst_addr;
  logic [DW-1:0] r_dst_data;
  logic          r_dst_we;
  logic          r_done;
  logic          r_err;
  wire w_en   = ~bus.i_EMU_CLK6MPCEN_n;
  wire w_trig = (bus.i_VCOUNTER == 9'(DMA_FIRST_LINE)) && (bus.i_HCOUNTER == 9'(TRIG_HCOUNT)) && bus.i_DMA_EN;
  wire w_over = bus.i_VCOUNTER > 9'(DMA_LAST_LINE);
  wire w_cpu  = r_state != COPY;
  // sequencer: trigger/arming, address issue, shadow writes delayed one enabled period, completion and overrun
  always_ff @(posedge i_EMU_MCLK or negedge i_MRST_n) begin
    if (!i_MRST_n) begin
      r_state    <= IDLE;
      r_rd_ptr   <= '0;
      r_fin      <= 1'b0;
      r_src_addr <= '0;
      r_dst_addr <= '0;
      r_dst_data <= '0;
      r_dst_we   <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else if (w_en) begin
      case (r_state)
        IDLE: if (w_trig) begin
          if (bus.i_CPU_CS_n) begin
            r_state    <= COPY;
            r_err      <= 1'b0;
            r_src_addr <= '0;
            r_rd_ptr   <= (AW+1)'(1);
            r_fin      <= 1'b0;
          end else r_state <= ARMED;
        end
        ARMED: if (w_over) begin
          r_err   <= 1'b1;
          r_state <= IDLE;
        end else if (bus.i_CPU_CS_n) begin
          r_state    <= COPY;
          r_err      <= 1'b0;
          r_src_addr <= '0;
          r_rd_ptr   <= (AW+1)'(1);
          r_fin      <= 1'b0;
        end
        COPY: if (w_over) begin
          r_err    <= 1'b1;
          r_dst_we <= 1'b0;
          r_state  <= IDLE;
        end else if (r_fin) begin
          r_dst_we <= 1'b0;
          r_done   <= 1'b1;
          r_state  <= DONE;
        end else begin
          r_dst_we   <= 1'b1;
          r_dst_addr <= r_src_addr;
          r_dst_data <= bus.i_SRC_DATA;
          if (r_rd_ptr == LP_WORDS) r_fin <= 1'b1;
          else begin
            r_src_addr <= r_rd_ptr[AW-1:0];
            r_rd_ptr   <= r_rd_ptr + 1'b1;
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end
  assign bus.o_SRC_ADDR   = w_cpu ? bus.i_CPU_ADDR : r_src_addr;
  assign bus.o_SRC_WE     = w_cpu & ~bus.i_CPU_CS_n & ~bus.i_CPU_WR_n;
  assign bus.o_CPU_WAIT_n = w_cpu | bus.i_CPU_CS_n;
  assign bus.o_BUSY       = (r_state == ARMED) || (r_state == COPY);
  assign bus.o_DST_ADDR   = r_dst_addr;
  assign bus.o_DST_DATA   = r_dst_data;
  assign bus.o_DST_WE     = r_dst_we;
  assign bus.o_DONE       = r_done;
  assign bus.o_DMA_ERR    = r_err;
endmodule

// File: tb/tb_obj_dma_scheduler.sv
// tb_obj_dma_scheduler: directed scenarios for the object DMA scheduler with a 16-word copy
module tb_obj_dma_scheduler;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_pass = 0;
  int n_chk = 0;
  logic [15:0] mem [1024];
  obj_dma_scheduler_if #(.AW(10), .DW(16)) bus ();
  obj_dma_scheduler #(.AW(10), .DW(16), .WORDS(16)) dut (.i_EMU_MCLK(clk), .i_MRST_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  assign bus.i_SRC_DATA = mem[bus.o_SRC_ADDR];

  // one disabled MCLK edge followed by one enabled edge; outputs sampled 1 ns later
  task automatic tick;
    bus.i_EMU_CLK6MPCEN_n = 1'b1;
    @(posedge clk); #1;
    bus.i_EMU_CLK6MPCEN_n = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic trigger(input logic cs_n);
    bus.i_VCOUNTER = 9'd479; bus.i_HCOUNTER = 9'd128; bus.i_CPU_CS_n = cs_n;
    tick();
    bus.i_VCOUNTER = 9'd480; bus.i_HCOUNTER = 9'd129;
  endtask

  task automatic test_reset;
    #3;
    n_chk++; if (bus.o_BUSY !== 1'b0) $display("FAIL reset_busy got %b want 0", bus.o_BUSY); else n_pass++;
    n_chk++; if (bus.o_DST_WE !== 1'b0) $display("FAIL reset_dst_we got %b want 0", bus.o_DST_WE); else n_pass++;
    n_chk++; if (bus.o_DONE !== 1'b0) $display("FAIL reset_done got %b want 0", bus.o_DONE); else n_pass++;
    n_chk++; if (bus.o_DMA_ERR !== 1'b0) $display("FAIL reset_err got %b want 0", bus.o_DMA_ERR); else n_pass++;
    n_chk++; if (bus.o_CPU_WAIT_n !== 1'b1) $display("FAIL reset_wait got %b want 1", bus.o_CPU_WAIT_n); else n_pass++;
    n_chk++; if ({bus.o_DST_ADDR, bus.o_DST_DATA} !== 26'd0) $display("FAIL reset_dst got %h/%h want 0/0", bus.o_DST_ADDR, bus.o_DST_DATA); else n_pass++;
    @(negedge clk) rst_n = 1'b1;
    tick();
  endtask

  task automatic test_copy;
    trigger(1'b1);
    n_chk++; if (bus.o_BUSY !== 1'b1) $display("FAIL copy_busy got %b want 1", bus.o_BUSY); else n_pass++;
    n_chk++; if (bus.o_SRC_ADDR !== 10'd0) $display("FAIL copy_src0 got %0d want 0", bus.o_SRC_ADDR); else n_pass++;
    n_chk++; if (bus.o_DST_WE !== 1'b0) $display("FAIL copy_we_e0 got %b want 0", bus.o_DST_WE); else n_pass++;
    for (int e = 1; e <= 16; e++) begin
      tick();
      n_chk++; if (bus.o_DST_WE !== 1'b1 || bus.o_DONE !== 1'b0) $display("FAIL copy_we e=%0d got we=%b done=%b want 1/0", e, bus.o_DST_WE, bus.o_DONE); else n_pass++;
      n_chk++; if (bus.o_DST_ADDR !== 10'(e-1)) $display("FAIL copy_addr e=%0d got %0d want %0d", e, bus.o_DST_ADDR, e-1); else n_pass++;
      n_chk++; if (bus.o_DST_DATA !== 16'(3*(e-1))) $display("FAIL copy_data e=%0d got %0d want %0d", e, bus.o_DST_DATA, 3*(e-1)); else n_pass++;
      if (e < 16) begin
        n_chk++; if (bus.o_SRC_ADDR !== 10'(e)) $display("FAIL copy_src e=%0d got %0d want %0d", e, bus.o_SRC_ADDR, e); else n_pass++;
      end
    end
    tick();
    n_chk++; if (bus.o_DONE !== 1'b1 || bus.o_DST_WE !== 1'b0) $display("FAIL copy_done17 got done=%b we=%b want 1/0", bus.o_DONE, bus.o_DST_WE); else n_pass++;
    n_chk++; if (bus.o_BUSY !== 1'b0) $display("FAIL copy_busy_done got %b want 0", bus.o_BUSY); else n_pass++;
    tick();
    n_chk++; if (bus.o_DONE !== 1'b0) $display("FAIL copy_done_pulse got %b want 0", bus.o_DONE); else n_pass++;
    n_chk++; if (bus.o_DMA_ERR !== 1'b0) $display("FAIL copy_err got %b want 0", bus.o_DMA_ERR); else n_pass++;
  endtask

  task automatic test_armed;
    bit seen = 0;
    bus.i_CPU_ADDR = 10'd5; bus.i_CPU_WR_n = 1'b1;
    trigger(1'b0);
    for (int e = 0; e < 5; e++) begin
      if (e > 0) tick();
      n_chk++; if (bus.o_BUSY !== 1'b1 || bus.o_CPU_WAIT_n !== 1'b1 || bus.o_DST_WE !== 1'b0) $display("FAIL armed_hold e=%0d got busy=%b wait=%b we=%b want 1/1/0", e, bus.o_BUSY, bus.o_CPU_WAIT_n, bus.o_DST_WE); else n_pass++;
      n_chk++; if (bus.o_SRC_ADDR !== 10'd5) $display("FAIL armed_pass e=%0d got %0d want 5", e, bus.o_SRC_ADDR); else n_pass++;
    end
    bus.i_CPU_CS_n = 1'b1;
    tick();
    n_chk++; if (bus.o_SRC_ADDR !== 10'd0 || bus.o_DST_WE !== 1'b0) $display("FAIL armed_entry got src=%0d we=%b want 0/0", bus.o_SRC_ADDR, bus.o_DST_WE); else n_pass++;
    tick();
    n_chk++; if (bus.o_DST_WE !== 1'b1 || bus.o_DST_ADDR !== 10'd0) $display("FAIL armed_first got we=%b addr=%0d want 1/0", bus.o_DST_WE, bus.o_DST_ADDR); else n_pass++;
    for (int i = 0; i < 40 && !seen; i++) begin tick(); seen = bus.o_DONE; end
    n_chk++; if (!seen) $display("FAIL armed_done got no done want done within 40"); else n_pass++;
    tick();
  endtask

  task automatic test_cpu_stall;
    bit bad = 0;
    trigger(1'b1);
    bus.i_CPU_CS_n = 1'b0; bus.i_CPU_WR_n = 1'b0; bus.i_CPU_ADDR = 10'd9;
    #1;
    for (int e = 1; e <= 17; e++) begin
      if (bus.o_CPU_WAIT_n !== 1'b0 || bus.o_SRC_WE !== 1'b0) bad = 1;
      tick();
    end
    n_chk++; if (bad) $display("FAIL stall_copy got wait/we not 0/0 during copy want 0/0"); else n_pass++;
    n_chk++; if (bus.o_DONE !== 1'b1 || bus.o_CPU_WAIT_n !== 1'b1) $display("FAIL stall_release got done=%b wait=%b want 1/1", bus.o_DONE, bus.o_CPU_WAIT_n); else n_pass++;
    n_chk++; if (bus.o_SRC_WE !== 1'b1 || bus.o_SRC_ADDR !== 10'd9) $display("FAIL stall_pass got we=%b addr=%0d want 1/9", bus.o_SRC_WE, bus.o_SRC_ADDR); else n_pass++;
    bus.i_CPU_CS_n = 1'b1; bus.i_CPU_WR_n = 1'b1;
    tick();
  endtask

  task automatic test_overrun;
    bit bad = 0;
    trigger(1'b1);
    repeat (5) tick();
    n_chk++; if (bus.o_DST_WE !== 1'b1 || bus.o_DST_ADDR !== 10'd4) $display("FAIL over_pre got we=%b addr=%0d want 1/4", bus.o_DST_WE, bus.o_DST_ADDR); else n_pass++;
    bus.i_VCOUNTER = 9'd495;
    tick();
    n_chk++; if (bus.o_DMA_ERR !== 1'b1) $display("FAIL over_err got %b want 1", bus.o_DMA_ERR); else n_pass++;
    n_chk++; if (bus.o_DST_WE !== 1'b0 || bus.o_BUSY !== 1'b0) $display("FAIL over_stop got we=%b busy=%b want 0/0", bus.o_DST_WE, bus.o_BUSY); else n_pass++;
    bus.i_VCOUNTER = 9'd0;
    for (int i = 0; i < 20; i++) begin
      if (bus.o_DONE !== 1'b0 || bus.o_DST_WE !== 1'b0) bad = 1;
      tick();
    end
    n_chk++; if (bad) $display("FAIL over_quiet got done/we activity want none"); else n_pass++;
  endtask

  task automatic test_dma_disabled;
    bit bad = 0;
    bus.i_DMA_EN = 1'b0; bus.i_CPU_CS_n = 1'b0; bus.i_CPU_WR_n = 1'b0; bus.i_CPU_ADDR = 10'd77;
    trigger(1'b0);
    for (int i = 0; i < 20; i++) begin
      if (bus.o_BUSY !== 1'b0 || bus.o_DST_WE !== 1'b0 || bus.o_CPU_WAIT_n !== 1'b1 || bus.o_SRC_WE !== 1'b1 || bus.o_SRC_ADDR !== 10'd77) bad = 1;
      bus.i_HCOUNTER = 9'(130 + i);
      tick();
    end
    n_chk++; if (bad) $display("FAIL dis_frame got copy activity or blocked cpu want passthrough"); else n_pass++;
    n_chk++; if (bus.o_DMA_ERR !== 1'b1) $display("FAIL dis_err got %b want 1", bus.o_DMA_ERR); else n_pass++;
    bus.i_DMA_EN = 1'b1; bus.i_CPU_CS_n = 1'b1; bus.i_CPU_WR_n = 1'b1; bus.i_VCOUNTER = 9'd0;
    tick();
  endtask

  task automatic test_err_clear;
    bit seen = 0;
    trigger(1'b1);
    n_chk++; if (bus.o_DMA_ERR !== 1'b0 || bus.o_BUSY !== 1'b1) $display("FAIL clr_err got err=%b busy=%b want 0/1", bus.o_DMA_ERR, bus.o_BUSY); else n_pass++;
    for (int i = 0; i < 30 && !seen; i++) begin tick(); seen = bus.o_DONE; end
    n_chk++; if (!seen) $display("FAIL clr_done got no done want done within 30"); else n_pass++;
    tick();
  endtask

  task automatic test_reset_mid;
    bit bad = 0;
    trigger(1'b1);
    repeat (6) tick();
    #2 rst_n = 1'b0;
    #1;
    n_chk++; if (bus.o_BUSY !== 1'b0 || bus.o_DST_WE !== 1'b0 || bus.o_DONE !== 1'b0) $display("FAIL rmid_ctl got busy=%b we=%b done=%b want 0/0/0", bus.o_BUSY, bus.o_DST_WE, bus.o_DONE); else n_pass++;
    n_chk++; if ({bus.o_DST_ADDR, bus.o_DST_DATA} !== 26'd0 || bus.o_CPU_WAIT_n !== 1'b1) $display("FAIL rmid_regs got %h/%h wait=%b want 0/0/1", bus.o_DST_ADDR, bus.o_DST_DATA, bus.o_CPU_WAIT_n); else n_pass++;
    @(negedge clk) rst_n = 1'b1;
    bus.i_VCOUNTER = 9'd300;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.o_DST_WE !== 1'b0 || bus.o_BUSY !== 1'b0) bad = 1;
    end
    n_chk++; if (bad) $display("FAIL rmid_resume got write after reset want none"); else n_pass++;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 16'(3*i);
    bus.i_EMU_CLK6MPCEN_n = 1'b1; bus.i_HCOUNTER = 9'd0; bus.i_VCOUNTER = 9'd0; bus.i_DMA_EN = 1'b1;
    bus.i_CPU_CS_n = 1'b1; bus.i_CPU_WR_n = 1'b1; bus.i_CPU_ADDR = 10'd0;
    test_reset();
    test_copy();
    test_armed();
    test_cpu_stall();
    test_overrun();
    test_dma_disabled();
    test_err_clear();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
